// File: rtl/matrix_slot_manager_pkg.sv
// Shared types, defaults and helpers for the matrix storage table.
package matrix_slot_manager_pkg;

    localparam int BRAM_ADDR_WIDTH = 11;
    localparam int DEF_NUM_SLOTS   = 10;
    localparam int DEF_SLOT_SHIFT  = 7;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_RESERVED = 2'd1,
        SLOT_VALID    = 2'd2
    } slot_state_e;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_HOLD = 1'b1
    } alloc_fsm_e;

    // Error codes are one-hot so both can be flagged on the same edge.
    localparam logic [1:0] ERR_NO_SLOT = 2'b01;
    localparam logic [1:0] ERR_COMMIT  = 2'b10;

    function automatic logic dim_ok(input logic [3:0] d);
        return (d >= 4'd1) && (d <= 4'd9);
    endfunction

    function automatic logic [3:0] wrap_add(input logic [3:0] base, input logic [3:0] k,
                                            input logic [3:0] n);
        logic [4:0] sum;
        sum = {1'b0, base} + {1'b0, k};
        return (sum >= {1'b0, n}) ? 4'(sum - {1'b0, n}) : sum[3:0];
    endfunction

endpackage

// File: rtl/matrix_slot_manager_slot_select.sv
// Combinational grant candidate search: lowest FREE slot, and the first VALID
// slot at or after the eviction pointer with wrap-around.
module slot_select
    import matrix_slot_manager_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic [2*NUM_SLOTS-1:0] i_state_vec,
    input  logic [3:0]             i_evict_ptr,
    output logic                   o_free_hit,
    output logic [3:0]             o_free_idx,
    output logic                   o_victim_hit,
    output logic [3:0]             o_victim_idx
);

    logic [3:0] w_idx;
    logic       w_free_here;
    logic       w_valid_here;

    // Scan downwards so the lowest index / nearest victim is the last writer.
    always_comb begin
        o_free_hit   = 1'b0;
        o_free_idx   = 4'd0;
        o_victim_hit = 1'b0;
        o_victim_idx = 4'd0;
        w_idx        = 4'd0;
        w_free_here  = 1'b0;
        w_valid_here = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_free_here = (i_state_vec[2*i +: 2] == SLOT_FREE);
            o_free_hit  = o_free_hit | w_free_here;
            o_free_idx  = w_free_here ? 4'(i) : o_free_idx;
        end
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            w_idx        = wrap_add(i_evict_ptr, 4'(k), 4'(NUM_SLOTS));
            w_valid_here = (i_state_vec[2*w_idx +: 2] == SLOT_VALID);
            o_victim_hit = o_victim_hit | w_valid_here;
            o_victim_idx = w_valid_here ? w_idx : o_victim_idx;
        end
    end

endmodule

// File: rtl/matrix_slot_manager.sv
// Matrix storage table: grants BRAM regions, records dimensions on commit,
// evicts the oldest VALID matrix when no FREE slot remains.
module matrix_slot_manager
    import matrix_slot_manager_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int SLOT_SHIFT = DEF_SLOT_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    output logic                  alloc_valid,
    output logic [3:0]            alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  alloc_err,
    input  logic                  commit_req,
    input  logic [3:0]            commit_slot,
    input  logic [3:0]            commit_m,
    input  logic [3:0]            commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    output logic                  commit_err,
    input  logic                  release_req,
    input  logic [3:0]            release_slot,
    input  logic [3:0]            query_slot,
    output logic                  query_valid,
    output logic [3:0]            query_m,
    output logic [3:0]            query_n,
    output logic [ADDR_WIDTH-1:0] query_addr,
    output logic [3:0]            valid_count
);

    localparam logic [3:0] NS = 4'(NUM_SLOTS);

    slot_state_e           r_state [NUM_SLOTS];
    logic [3:0]            r_m     [NUM_SLOTS];
    logic [3:0]            r_n     [NUM_SLOTS];
    slot_state_e           w_nxt_state [NUM_SLOTS];
    logic [3:0]            w_nxt_m [NUM_SLOTS];
    logic [3:0]            w_nxt_n [NUM_SLOTS];
    alloc_fsm_e            r_fsm;
    logic [3:0]            r_evict_ptr;
    logic                  r_alloc_valid;
    logic [3:0]            r_alloc_slot;
    logic [ADDR_WIDTH-1:0] r_alloc_addr;
    logic [1:0]            r_err;
    logic                  r_query_valid;
    logic [3:0]            r_query_m;
    logic [3:0]            r_query_n;
    logic [ADDR_WIDTH-1:0] r_query_addr;
    logic [3:0]            r_valid_count;

    logic [2*NUM_SLOTS-1:0] w_state_vec;
    logic                  w_free_hit;
    logic [3:0]            w_free_idx;
    logic                  w_victim_hit;
    logic [3:0]            w_victim_idx;
    logic                  w_req_idle;
    logic                  w_grant;
    logic                  w_evict;
    logic                  w_no_slot;
    logic [3:0]            w_grant_idx;
    logic [ADDR_WIDTH-1:0] w_grant_addr;
    logic [ADDR_WIDTH-1:0] w_commit_base;
    logic                  w_commit_rsv;
    logic                  w_release_rsv;
    logic                  w_commit_ok;
    logic                  w_release_ok;
    logic [3:0]            w_vcnt;
    logic                  w_q_hit;
    logic                  w_q_valid;
    logic [3:0]            w_q_m;
    logic [3:0]            w_q_n;
    logic [ADDR_WIDTH-1:0] w_q_addr;

    slot_select #(.NUM_SLOTS(NUM_SLOTS)) u_slot_select (
        .i_state_vec  (w_state_vec),
        .i_evict_ptr  (r_evict_ptr),
        .o_free_hit   (w_free_hit),
        .o_free_idx   (w_free_idx),
        .o_victim_hit (w_victim_hit),
        .o_victim_idx (w_victim_idx)
    );

    // Pack table state, qualify requests against the pre-edge table, count VALID slots.
    always_comb begin
        w_state_vec   = '0;
        w_commit_rsv  = 1'b0;
        w_release_rsv = 1'b0;
        w_vcnt        = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_state_vec[2*i +: 2] = r_state[i];
            w_commit_rsv  = w_commit_rsv  | ((commit_slot == 4'(i))  && (r_state[i] == SLOT_RESERVED));
            w_release_rsv = w_release_rsv | ((release_slot == 4'(i)) && (r_state[i] == SLOT_RESERVED));
            w_vcnt        = w_vcnt + {3'd0, (r_state[i] == SLOT_VALID)};
        end
        w_req_idle    = alloc_req && (r_fsm == FSM_IDLE);
        w_grant       = w_req_idle && (w_free_hit || w_victim_hit);
        w_evict       = w_grant && !w_free_hit;
        w_no_slot     = w_req_idle && !w_free_hit && !w_victim_hit;
        w_grant_idx   = w_free_hit ? w_free_idx : w_victim_idx;
        w_grant_addr  = {{(ADDR_WIDTH-4){1'b0}}, w_grant_idx} << SLOT_SHIFT;
        w_commit_base = {{(ADDR_WIDTH-4){1'b0}}, commit_slot} << SLOT_SHIFT;
        w_commit_ok   = commit_req && (commit_slot < NS) && w_commit_rsv &&
                        (commit_addr == w_commit_base) && dim_ok(commit_m) && dim_ok(commit_n);
        // A commit addressed to the same slot always shadows the release.
        w_release_ok  = release_req && (release_slot < NS) && w_release_rsv &&
                        !(commit_req && (commit_slot == release_slot));
    end

    // Next table contents; query reads these so it reflects the post-edge table.
    always_comb begin
        w_q_valid = 1'b0;
        w_q_m     = 4'd0;
        w_q_n     = 4'd0;
        w_q_addr  = '0;
        w_q_hit   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_nxt_state[i] = r_state[i];
            w_nxt_m[i]     = r_m[i];
            w_nxt_n[i]     = r_n[i];
            if (w_grant && (w_grant_idx == 4'(i))) begin
                w_nxt_state[i] = SLOT_RESERVED;
                w_nxt_m[i]     = 4'd0;
                w_nxt_n[i]     = 4'd0;
            end else if (w_commit_ok && (commit_slot == 4'(i))) begin
                w_nxt_state[i] = SLOT_VALID;
                w_nxt_m[i]     = commit_m;
                w_nxt_n[i]     = commit_n;
            end else if (w_release_ok && (release_slot == 4'(i))) begin
                w_nxt_state[i] = SLOT_FREE;
            end else begin
                w_nxt_state[i] = r_state[i];
            end
            w_q_hit   = (query_slot == 4'(i)) && (w_nxt_state[i] == SLOT_VALID);
            w_q_valid = w_q_valid | w_q_hit;
            w_q_m     = w_q_m | (w_q_hit ? w_nxt_m[i] : 4'd0);
            w_q_n     = w_q_n | (w_q_hit ? w_nxt_n[i] : 4'd0);
            w_q_addr  = w_q_addr | (w_q_hit ? ({{(ADDR_WIDTH-4){1'b0}}, 4'(i)} << SLOT_SHIFT) : '0);
        end
    end

    // Slot table registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= SLOT_FREE;
                r_m[i]     <= 4'd0;
                r_n[i]     <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_nxt_state[i];
                r_m[i]     <= w_nxt_m[i];
                r_n[i]     <= w_nxt_n[i];
            end
        end
    end

    // Allocation FSM: HOLD swallows a request still held after its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm         <= FSM_IDLE;
            r_alloc_valid <= 1'b0;
            r_alloc_slot  <= 4'd0;
            r_alloc_addr  <= '0;
            r_evict_ptr   <= 4'd0;
        end else begin
            r_alloc_valid <= 1'b0;
            case (r_fsm)
                FSM_IDLE: begin
                    if (alloc_req) begin
                        r_fsm <= FSM_HOLD;
                    end else begin
                        r_fsm <= FSM_IDLE;
                    end
                    if (w_grant) begin
                        r_alloc_valid <= 1'b1;
                        r_alloc_slot  <= w_grant_idx;
                        r_alloc_addr  <= w_grant_addr;
                    end else begin
                        r_alloc_slot  <= r_alloc_slot;
                    end
                    if (w_evict) begin
                        r_evict_ptr <= wrap_add(w_victim_idx, 4'd1, NS);
                    end else begin
                        r_evict_ptr <= r_evict_ptr;
                    end
                end
                FSM_HOLD: begin
                    r_fsm <= alloc_req ? FSM_HOLD : FSM_IDLE;
                end
                default: begin
                    r_fsm <= FSM_IDLE;
                end
            endcase
        end
    end

    // Error pulses, query response and VALID count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err         <= 2'd0;
            r_query_valid <= 1'b0;
            r_query_m     <= 4'd0;
            r_query_n     <= 4'd0;
            r_query_addr  <= '0;
            r_valid_count <= 4'd0;
        end else begin
            r_err         <= (w_no_slot ? ERR_NO_SLOT : 2'd0) |
                             ((commit_req && !w_commit_ok) ? ERR_COMMIT : 2'd0);
            r_query_valid <= w_q_valid;
            r_query_m     <= w_q_m;
            r_query_n     <= w_q_n;
            r_query_addr  <= w_q_addr;
            r_valid_count <= w_vcnt;
        end
    end

    assign alloc_valid = r_alloc_valid;
    assign alloc_slot  = r_alloc_slot;
    assign alloc_addr  = r_alloc_addr;
    assign alloc_err   = |(r_err & ERR_NO_SLOT);
    assign commit_err  = |(r_err & ERR_COMMIT);
    assign query_valid = r_query_valid;
    assign query_m     = r_query_m;
    assign query_n     = r_query_n;
    assign query_addr  = r_query_addr;
    assign valid_count = r_valid_count;

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Directed bench for matrix_slot_manager with a table-level reference model
// compared every cycle, plus literal expectations on key scenarios.
module tb_matrix_slot_manager;

    localparam int AW = 11;
    localparam int NS = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_req = 1'b0;
    logic          alloc_valid;
    logic [3:0]    alloc_slot;
    logic [AW-1:0] alloc_addr;
    logic          alloc_err;
    logic          commit_req = 1'b0;
    logic [3:0]    commit_slot = 4'd0;
    logic [3:0]    commit_m = 4'd0;
    logic [3:0]    commit_n = 4'd0;
    logic [AW-1:0] commit_addr = '0;
    logic          commit_err;
    logic          release_req = 1'b0;
    logic [3:0]    release_slot = 4'd0;
    logic [3:0]    query_slot = 4'd0;
    logic          query_valid;
    logic [3:0]    query_m;
    logic [3:0]    query_n;
    logic [AW-1:0] query_addr;
    logic [3:0]    valid_count;

    always #5 clk = ~clk;

    matrix_slot_manager dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_slot(alloc_slot),
        .alloc_addr(alloc_addr), .alloc_err(alloc_err),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr), .commit_err(commit_err),
        .release_req(release_req), .release_slot(release_slot),
        .query_slot(query_slot), .query_valid(query_valid), .query_m(query_m),
        .query_n(query_n), .query_addr(query_addr), .valid_count(valid_count)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit go = 1'b0;

    // Reference model: 0 free, 1 reserved, 2 valid.
    int st [NS];
    int mm [NS];
    int nn [NS];
    int ptr = 0;
    bit hold = 1'b0;
    int e_av = 0, e_aslot = 0, e_aaddr = 0, e_aerr = 0, e_cerr = 0;
    int e_qv = 0, e_qm = 0, e_qn = 0, e_qaddr = 0, e_vc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin st[i] = 0; mm[i] = 0; nn[i] = 0; end
        ptr = 0; hold = 1'b0;
        e_av = 0; e_aslot = 0; e_aaddr = 0; e_aerr = 0; e_cerr = 0;
        e_qv = 0; e_qm = 0; e_qn = 0; e_qaddr = 0; e_vc = 0;
    endtask

    task automatic model_step();
        int  vc, g, cs, rs, q;
        bit  c_ok, r_ok;
        vc = 0;
        for (int i = 0; i < NS; i++) if (st[i] == 2) vc++;
        cs = int'(commit_slot);
        rs = int'(release_slot);
        c_ok = 1'b0;
        if (commit_req && cs < NS)
            c_ok = (st[cs] == 1) && (int'(commit_addr) == cs * 128) &&
                   (commit_m >= 1) && (commit_m <= 9) && (commit_n >= 1) && (commit_n <= 9);
        r_ok = 1'b0;
        if (release_req && rs < NS)
            r_ok = (st[rs] == 1) && !(commit_req && cs == rs);
        e_av = 0; e_aerr = 0; g = -1;
        if (!hold) begin
            if (alloc_req) begin
                hold = 1'b1;
                for (int i = 0; i < NS; i++) if (g < 0 && st[i] == 0) g = i;
                if (g < 0) begin
                    for (int k = 0; k < NS; k++)
                        if (g < 0 && st[(ptr + k) % NS] == 2) g = (ptr + k) % NS;
                    if (g >= 0) ptr = (g + 1) % NS;
                end
                if (g >= 0) begin e_av = 1; e_aslot = g; e_aaddr = g * 128; end
                else e_aerr = 1;
            end
        end else if (!alloc_req) begin
            hold = 1'b0;
        end
        if (g >= 0) begin st[g] = 1; mm[g] = 0; nn[g] = 0; end
        if (c_ok) begin st[cs] = 2; mm[cs] = int'(commit_m); nn[cs] = int'(commit_n); end
        if (r_ok) st[rs] = 0;
        e_cerr = (commit_req && !c_ok) ? 1 : 0;
        e_vc = vc;
        q = int'(query_slot);
        if (q < NS && st[q] == 2) begin
            e_qv = 1; e_qm = mm[q]; e_qn = nn[q]; e_qaddr = q * 128;
        end else begin
            e_qv = 0; e_qm = 0; e_qn = 0; e_qaddr = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        wait (go);
        forever begin
            @(negedge clk);
            check("alloc_valid", alloc_valid, e_av);
            check("alloc_slot",  alloc_slot,  e_aslot);
            check("alloc_addr",  alloc_addr,  e_aaddr);
            check("alloc_err",   alloc_err,   e_aerr);
            check("commit_err",  commit_err,  e_cerr);
            check("query_valid", query_valid, e_qv);
            check("query_m",     query_m,     e_qm);
            check("query_n",     query_n,     e_qn);
            check("query_addr",  query_addr,  e_qaddr);
            check("valid_count", valid_count, e_vc);
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0; alloc_req = 1'b0; commit_req = 1'b0; release_req = 1'b0;
        @(negedge clk); @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic alloc(output int v, output int s, output int e);
        @(negedge clk); alloc_req = 1'b1;
        @(negedge clk); v = alloc_valid; s = alloc_slot; e = alloc_err; alloc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse(input logic cr, input logic [3:0] cs, input logic [3:0] cm,
                         input logic [3:0] cn, input logic [AW-1:0] ca, input logic rr,
                         input logic [3:0] rs, input logic [3:0] qs);
        @(negedge clk);
        commit_req = cr; commit_slot = cs; commit_m = cm; commit_n = cn; commit_addr = ca;
        release_req = rr; release_slot = rs; query_slot = qs;
        @(negedge clk);
        commit_req = 1'b0; release_req = 1'b0;
    endtask

    int v, s, e;

    initial begin
        @(posedge clk); @(posedge clk); #1;
        go = 1'b1;
        // Reset state and a request held for 3 cycles.
        do_reset();
        check("rst_alloc_valid", alloc_valid, 0);
        check("rst_valid_count", valid_count, 0);
        @(negedge clk); alloc_req = 1'b1;
        @(negedge clk);
        check("hold_grant", alloc_valid, 1);
        check("hold_slot", alloc_slot, 0);
        check("hold_addr", alloc_addr, 0);
        @(negedge clk); check("hold_no_regrant1", alloc_valid, 0);
        @(negedge clk); check("hold_no_regrant2", alloc_valid, 0);
        alloc_req = 1'b0;
        @(negedge clk);
        alloc(v, s, e); check("after_hold_slot", s, 1);

        // Single allocate, commit, query.
        do_reset();
        alloc(v, s, e); check("t2_slot", s, 0);
        pulse(1'b1, 4'd0, 4'd2, 4'd3, 11'h000, 1'b0, 4'd0, 4'd0);
        check("t2_commit_err", commit_err, 0);
        check("t2_qvalid", query_valid, 1);
        check("t2_qm", query_m, 2);
        check("t2_qn", query_n, 3);
        @(negedge clk); check("t2_vcount", valid_count, 1);

        // Fill and commit all slots, then evict twice.
        do_reset();
        for (int i = 0; i < NS; i++) begin
            alloc(v, s, e);
            check("fill_slot", s, i);
            pulse(1'b1, 4'(i), 4'((i % 9) + 1), 4'(9 - (i % 9)), 11'(i * 128), 1'b0, 4'd0, 4'(i));
            check("fill_commit_err", commit_err, 0);
        end
        alloc(v, s, e); check("evict1_slot", s, 0);
        alloc(v, s, e); check("evict2_slot", s, 1);
        check("evict2_addr", alloc_addr, 11'h080);
        check("model_evict_ptr", ptr, 2);
        @(negedge clk); check("evict_vcount", valid_count, 8);

        // All slots reserved: no grant possible.
        do_reset();
        for (int i = 0; i < NS; i++) alloc(v, s, e);
        alloc(v, s, e);
        check("full_no_valid", v, 0);
        check("full_err", e, 1);

        // Rejected commits leave the table unchanged.
        do_reset();
        alloc(v, s, e);
        pulse(1'b1, 4'd0, 4'd2, 4'd2, 11'h080, 1'b0, 4'd0, 4'd0);
        check("bad_addr_err", commit_err, 1); check("bad_addr_q", query_valid, 0);
        pulse(1'b1, 4'd0, 4'd0, 4'd2, 11'h000, 1'b0, 4'd0, 4'd0);
        check("m0_err", commit_err, 1);
        pulse(1'b1, 4'd0, 4'd10, 4'd2, 11'h000, 1'b0, 4'd0, 4'd0);
        check("m10_err", commit_err, 1);
        pulse(1'b1, 4'd5, 4'd2, 4'd2, 11'h280, 1'b0, 4'd0, 4'd5);
        check("free_slot_err", commit_err, 1);
        pulse(1'b1, 4'd12, 4'd2, 4'd2, 11'h600, 1'b0, 4'd0, 4'd12);
        check("oob_slot_err", commit_err, 1); check("oob_query", query_valid, 0);
        pulse(1'b1, 4'd0, 4'd9, 4'd9, 11'h000, 1'b0, 4'd0, 4'd0);
        check("max_dims_ok", commit_err, 0); check("max_dims_qm", query_m, 9);

        // Commit beats release on the same slot; release frees a reserved slot.
        do_reset();
        alloc(v, s, e); alloc(v, s, e);
        pulse(1'b1, 4'd0, 4'd4, 4'd5, 11'h000, 1'b1, 4'd0, 4'd0);
        check("cr_qvalid", query_valid, 1); check("cr_qn", query_n, 5);
        pulse(1'b0, 4'd0, 4'd0, 4'd0, 11'h000, 1'b1, 4'd1, 4'd1);
        pulse(1'b0, 4'd0, 4'd0, 4'd0, 11'h000, 1'b1, 4'd5, 4'd0);
        alloc(v, s, e); check("release_regrant", s, 1);
        alloc(v, s, e); check("next_free", s, 2);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
